// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: loads a multi-hot vector and emits the index of every set bit,
// one per handshake, highest-first or lowest-first depending on MSB_FIRST.
module enc8to3_seq #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       zero
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic       zero_q, zero_d;

  logic [2:0] idx;
  logic       single;
  logic       accept;
  logic       xfer;

  // Priority pick: the last match in the scan wins, so scan order selects MSB or LSB first.
  always_comb begin
    idx = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_q[i]) idx = 3'(i);
      end
    end
  end

  assign single = (pend_q != 8'd0) && ((pend_q & (pend_q - 8'd1)) == 8'd0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= 8'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic; accept and xfer already fold in en, so en=0 freezes everything.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in != 8'd0) begin
            pend_d  = in;
            state_d = StSend;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      StSend: begin
        if (xfer) begin
          pend_d = pend_q & ~(8'd1 << idx);
          if (single) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = en && (state_q == StIdle);
    out_valid = en && (state_q == StSend);
    accept    = in_ready && in_valid;
    xfer      = out_valid && out_ready;
    out_last  = (state_q == StSend) && single;
    out       = out_valid ? idx : 3'd0;
    zero      = zero_q && en;
  end

endmodule

// File: tb/tb_enc8to3_seq.sv
// Scoreboard bench for enc8to3_seq: MSB-first and LSB-first instances share stimulus,
// monitors pop expected {index,last} pairs on every transfer.
module tb_enc8to3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] in;
  logic       in_valid;
  logic       out_ready;

  logic       m_in_ready, m_out_valid, m_out_last, m_zero;
  logic [2:0] m_out;
  logic       l_in_ready, l_out_valid, l_out_last, l_zero;
  logic [2:0] l_out;

  int checks = 0;
  int errors = 0;
  int nxfer  = 0;

  logic [3:0] qm[$];
  logic [3:0] ql[$];
  logic [7:0] vq[$];
  logic [7:0] acc = 8'd0;

  always #5 clk = ~clk;

  enc8to3_seq #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid), .in_ready(m_in_ready),
    .out(m_out), .out_valid(m_out_valid), .out_ready(out_ready), .out_last(m_out_last),
    .zero(m_zero)
  );

  enc8to3_seq #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid), .in_ready(l_in_ready),
    .out(l_out), .out_valid(l_out_valid), .out_ready(out_ready), .out_last(l_out_last),
    .zero(l_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // MSB-first monitor with round-trip decode accumulation.
  always @(negedge clk) begin
    if (!rst && m_out_valid && out_ready) begin
      nxfer++;
      if (qm.size() == 0) begin
        chk("msb_unexpected_xfer", {m_out, m_out_last}, 32'hff);
      end else begin
        chk("msb_idx_last", {m_out, m_out_last}, qm.pop_front());
      end
      acc = acc | (8'd1 << m_out);
      if (m_out_last) begin
        if (vq.size() == 0) chk("roundtrip_unexpected", acc, 32'h1ff);
        else chk("roundtrip", acc, vq.pop_front());
        acc = 8'd0;
      end
    end
  end

  // LSB-first monitor.
  always @(negedge clk) begin
    if (!rst && l_out_valid && out_ready) begin
      if (ql.size() == 0) chk("lsb_unexpected_xfer", {l_out, l_out_last}, 32'hff);
      else chk("lsb_idx_last", {l_out, l_out_last}, ql.pop_front());
    end
  end

  function automatic void push_m(input int idx, input bit last);
    qm.push_back({3'(idx), last});
  endfunction

  // Called at posedge+1 with both instances idle and en=1.
  task automatic load(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        n++;
        ql.push_back({3'(i), (v >> (i + 1)) == 8'd0});
      end
    end
    if (v != 8'd0) vq.push_back(v);
    in = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in = 8'd0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(m_in_ready && l_in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk(name, 0, 1);
  endtask

  int base;

  initial begin
    rst = 1'b1; en = 1'b1; in = 8'd0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", m_out_valid, 0);
    chk("rst_out", m_out, 0);
    chk("rst_out_last", m_out_last, 0);
    chk("rst_in_ready", m_in_ready, 1);
    chk("rst_zero", m_zero, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1010_0100 at full throughput: 7,5,2 back to back.
    push_m(7, 0); push_m(5, 0); push_m(2, 1);
    base = nxfer;
    load(8'b1010_0100);
    @(negedge clk);
    chk("t30_first_out", m_out, 7);
    chk("t30_in_ready_busy", m_in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t30_xfer_count", nxfer - base, 3);
    chk("t30_in_ready_next", m_in_ready, 1);
    chk("t30_out_valid_done", m_out_valid, 0);
    @(posedge clk); #1;

    // Single bit with backpressure.
    out_ready = 1'b0;
    push_m(0, 1);
    base = nxfer;
    load(8'b0000_0001);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t31_hold_valid", m_out_valid, 1);
      chk("t31_hold_out", {m_out, m_out_last}, {3'd0, 1'b1});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t31_xfer_count", nxfer - base, 1);
    chk("t31_idle", m_in_ready, 1);
    @(posedge clk); #1;

    // All-zero vector.
    load(8'h00);
    @(negedge clk);
    chk("t32_zero_pulse", m_zero, 1);
    chk("t32_no_valid", m_out_valid, 0);
    chk("t32_in_ready", m_in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t32_zero_clear", m_zero, 0);
    @(posedge clk); #1;

    // FF with en dropped for 3 cycles after two transfers.
    for (int i = 7; i >= 0; i--) push_m(i, i == 0);
    base = nxfer;
    load(8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t33_frozen_valid", m_out_valid, 0);
      chk("t33_frozen_in_ready", m_in_ready, 0);
      @(posedge clk); #1;
    end
    chk("t33_count_at_freeze", nxfer - base, 2);
    en = 1'b1;
    @(negedge clk);
    chk("t33_resume_out", m_out, 5);
    @(posedge clk); #1;
    wait_idle("t33_timeout");
    chk("t33_xfer_count", nxfer - base, 8);

    // Reset mid-send discards the remainder.
    push_m(6, 0);
    load(8'b0110_0000);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t34_rst_valid", m_out_valid, 0);
    chk("t34_rst_out", m_out, 0);
    chk("t34_rst_pend", dut.pend_q, 0);
    qm.delete(); ql.delete(); vq.delete(); acc = 8'd0;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_m(3, 1);
    load(8'b0000_1000);
    @(negedge clk);
    chk("t34_reload_out", {m_out, m_out_last}, {3'd3, 1'b1});
    @(posedge clk); #1;
    wait_idle("t34_timeout");

    // Exhaustive round-trip sweep on both instances.
    for (int v = 0; v < 256; v++) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) push_m(i, (v & ((1 << i) - 1)) == 0);
      end
      load(8'(v));
      wait_idle("t35_timeout");
    end
    @(posedge clk); #1;

    chk("drain_msb", qm.size(), 0);
    chk("drain_lsb", ql.size(), 0);
    chk("drain_vec", vq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
